// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI3 bridge: fixed AXI fields, transaction IDs
// and the encodings of the read-address and write channel state machines.
package sram_axi_bridge_pkg;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'd0;
    localparam logic [2:0] AXI_PROT  = 3'd0;

    localparam logic [3:0] AXI_INST_ID = 4'd0;
    localparam logic [3:0] AXI_DATA_ID = 4'd1;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // SRAM size is log2(bytes) on two bits; AXI carries the same value on three.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Lets the fetch and data SRAM-like ports share one AXI3 master. There is at most one
// outstanding read per requester and one outstanding data op, each as a single beat.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = AXI_INST_ID,
    parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    ar_state_e   ar_state_r, ar_state_s;
    w_state_e    w_state_r, w_state_s;
    logic        inst_busy_r, data_busy_r;
    logic [31:0] araddr_r, awaddr_r, wdata_r;
    logic [2:0]  arsize_r, awsize_r;
    logic [3:0]  arid_r, wstrb_r;
    logic        awvalid_r, wvalid_r;

    logic data_rd_s, inst_rd_s, data_wr_s;
    logic data_rd_acc_s, inst_acc_s, data_wr_acc_s;
    logic r_inst_s, r_data_s, b_done_s;
    logic unused_s;

    // Data reads win the shared AR channel over fetch; writes only need the W FSM idle.
    assign data_rd_s     = data_sram_req & ~data_sram_wr & ~data_busy_r;
    assign data_wr_s     = data_sram_req &  data_sram_wr & ~data_busy_r;
    assign inst_rd_s     = inst_sram_req & ~inst_busy_r;
    assign data_rd_acc_s = (ar_state_r == AR_IDLE) & data_rd_s;
    assign inst_acc_s    = (ar_state_r == AR_IDLE) & inst_rd_s & ~data_rd_s;
    assign data_wr_acc_s = (w_state_r == W_IDLE) & data_wr_s;
    assign r_inst_s      = rvalid & (rid == INST_ID);
    assign r_data_s      = rvalid & (rid == DATA_ID);
    assign b_done_s      = bvalid & (w_state_r == W_RESP);

    // Read-address channel next state.
    always_comb begin
        ar_state_s = ar_state_r;
        case (ar_state_r)
            AR_IDLE: begin
                if (data_rd_acc_s | inst_acc_s) ar_state_s = AR_SEND;
                else                            ar_state_s = AR_IDLE;
            end
            AR_SEND: begin
                if (arready) ar_state_s = AR_IDLE;
                else         ar_state_s = AR_SEND;
            end
            default: ar_state_s = AR_IDLE;
        endcase
    end

    // Write channel next state; AW and W complete independently before the response wait.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (data_wr_acc_s) w_state_s = W_SEND;
                else               w_state_s = W_IDLE;
            end
            W_SEND: begin
                if (~(awvalid_r & ~awready) & ~(wvalid_r & ~wready)) w_state_s = W_RESP;
                else                                                w_state_s = W_SEND;
            end
            W_RESP: begin
                if (bvalid) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // AR state, latched read request and the per-requester outstanding flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_r  <= AR_IDLE;
            araddr_r    <= 32'd0;
            arsize_r    <= 3'd0;
            arid_r      <= 4'd0;
            inst_busy_r <= 1'b0;
            data_busy_r <= 1'b0;
        end else begin
            ar_state_r  <= ar_state_s;
            inst_busy_r <= inst_acc_s | (inst_busy_r & ~r_inst_s);
            data_busy_r <= data_rd_acc_s | data_wr_acc_s | (data_busy_r & ~(r_data_s | bvalid));
            if (data_rd_acc_s) begin
                araddr_r <= data_sram_addr;
                arsize_r <= axi_size(data_sram_size);
                arid_r   <= DATA_ID;
            end else if (inst_acc_s) begin
                araddr_r <= inst_sram_addr;
                arsize_r <= axi_size(inst_sram_size);
                arid_r   <= INST_ID;
            end
        end
    end

    // Write state, latched write request and the separate AW/W valid flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_r <= W_IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            awaddr_r  <= 32'd0;
            awsize_r  <= 3'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
        end else begin
            w_state_r <= w_state_s;
            if (data_wr_acc_s) begin
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
                awaddr_r  <= data_sram_addr;
                awsize_r  <= axi_size(data_sram_size);
                wdata_r   <= data_sram_wdata;
                wstrb_r   <= data_sram_wstrb;
            end else begin
                awvalid_r <= awvalid_r & ~awready;
                wvalid_r  <= wvalid_r & ~wready;
            end
        end
    end

    assign inst_sram_addr_ok = inst_acc_s;
    assign inst_sram_data_ok = r_inst_s;
    assign inst_sram_rdata   = rdata;
    assign data_sram_addr_ok = data_rd_acc_s | data_wr_acc_s;
    assign data_sram_data_ok = r_data_s | b_done_s;
    assign data_sram_rdata   = rdata;

    assign arid    = arid_r;
    assign araddr  = araddr_r;
    assign arsize  = arsize_r;
    assign arvalid = (ar_state_r == AR_SEND);
    assign arlen   = AXI_LEN;
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign rready  = 1'b1;

    assign awid    = DATA_ID;
    assign awaddr  = awaddr_r;
    assign awsize  = awsize_r;
    assign awvalid = awvalid_r;
    assign awlen   = AXI_LEN;
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;

    assign wid    = DATA_ID;
    assign wdata  = wdata_r;
    assign wstrb  = wstrb_r;
    assign wlast  = 1'b1;
    assign wvalid = wvalid_r;
    assign bready = 1'b1;

    // Fetch never writes, responses are always OKAY-treated and every beat is last.
    assign unused_s = ^{inst_sram_wr, rresp, rlast, bid, bresp};

endmodule
